fixed_divider: RTL and testbench
================================

# fixed_divider

- Sequential signed fixed-point divider for the digital filter datapath; the inverse companion of the saturating fixed-point multiplier.
- Operands and result use the same format: two's complement, N bits, N/2 fractional bits (Q8.8 at N=16).
- Computes A/B by restoring division, one quotient bit per clock, and saturates on overflow exactly as the multiplier does.
- Feeds gain normalisation and coefficient scaling blocks that tolerate multi-cycle latency.

## Interface
- N, default 16, operand/result width; must be even and ≥4; fractional bits = N/2.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  N  dividend, sampled on the accepting edge.
- B  input  N  divisor, sampled on the accepting edge.
- Result  output  N  quotient, registered, held until the next completion.
- done  output  1  one-cycle pulse; Result valid from this cycle.
- busy  output  1  high from the accepting edge until done is asserted.
- div_zero  output  1  registered with Result; high when the sampled B was 0.

## Operation
- States:
  - IDLE: on start=1, capture |A| and |B| as N-bit unsigned magnitudes (0x8000 maps to 32768), the sign, and the B==0 flag; load the iteration counter; go to CALC.
  - CALC: one restoring step per cycle on dividend |A|<<(N/2), width N+N/2; run K = N+N/2 iterations; after the last one go to FINAL.
  - FINAL: apply the sign and saturation, write Result and div_zero, pulse done, go to IDLE.
- neg = A[N-1] XOR B[N-1].
- Overflow: any quotient magnitude bit at position ≥ N-1 is set.
- Result selection in FINAL, in priority order:
  - A==0 (including B==0): 0.
  - B==0, A>0: 0x7FFF pattern {0,1…1}.
  - B==0, A<0: 0x8001 pattern {1,0…0,1}.
  - Overflow: 0x7FFF if not neg, 0x8001 if neg.
  - Otherwise: the magnitude, negated in two's complement if neg.
- Truncation is toward zero on the magnitude.
- start while busy is ignored; it is neither queued nor does it disturb the computation.
- A and B may change freely after the accepting edge.

## Timing
- Reset values: Result=0, done=0, busy=0, div_zero=0, state=IDLE. Reset mid-operation aborts immediately and produces no done.
- Latency is fixed and data-independent; B==0 is not short-circuited.
  - Start accepted at edge k.
  - done and the new Result appear after edge k+K+1; that is edge k+25 for N=16.
- done is high for exactly one cycle; busy falls on the same edge that raises done.
- start asserted in the done cycle is accepted, so back-to-back throughput is one division per K+2 cycles.

## Configuration
- FIXED_DIVIDER_ROUND_EN defined:
  - One extra guard-quotient bit is computed, so K = N+N/2+1 and latency grows by one cycle.
  - The magnitude is rounded half away from zero (the guard bit is added) before the overflow check and sign application.
- Not defined: truncation, K = N+N/2.

## Structure
- Package fixed_divider_pkg holds:
  - state_t enum {IDLE, CALC, FINAL}.
  - Function sat_pos(N) returning {0,1…1}.
  - Function sat_neg(N) returning {1,0…0,1}.
- The multiplier shares the two saturation functions.
- One sub-module, fixed_div_step: combinational single restoring iteration (partial remainder, divisor, next dividend bit → new remainder, quotient bit). Instantiated once.

## Test plan
- A=0x0300, B=0x0200, start pulse → after 25 cycles done=1, Result=0x0180, div_zero=0; busy high for the intervening cycles.
- A=0xFD00, B=0x0200 → Result=0xFE80. A=0xFD00, B=0xFE00 → Result=0x0180.
- A=0x0200, B=0x0300 → Result=0x00AA without the macro; 0x00AB with FIXED_DIVIDER_ROUND_EN, done one cycle later.
- Overflow and zero cases:
  - A=0x7F00, B=0x0080 → 0x7FFF.
  - A=0x8100, B=0x0080 → 0x8001.
  - A=0x0100, B=0 → 0x7FFF, div_zero=1.
  - A=0xFF00, B=0 → 0x8001, div_zero=1.
  - A=0, B=0 → 0x0000, div_zero=1.
- Busy and back-to-back handling:
  - Second start with different operands 5 cycles after the first → ignored; the first result is unaffected.
  - start in the done cycle → accepted; the next done follows K+2 cycles after the previous one.
- Reset handling:
  - rst_n low for one cycle at iteration 10 → all outputs 0 immediately, no done.
  - A new start after release completes normally with the correct result.

Source files
------------

// File: rtl/fixed_divider_pkg.sv
// Shared types and saturation helpers for the fixed-point divider and multiplier.
package fixed_divider_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FINAL} state_t;

    localparam int MAX_W = 64;

    // Largest positive value of an n-bit two's complement word: {0,1..1}.
    function automatic logic [MAX_W-1:0] sat_pos(input int n);
        return (MAX_W'(1) << (n - 1)) - MAX_W'(1);
    endfunction

    // Symmetric negative limit: {1,0..0,1}, so |sat_neg| == sat_pos.
    function automatic logic [MAX_W-1:0] sat_neg(input int n);
        return (MAX_W'(1) << (n - 1)) | MAX_W'(1);
    endfunction

endpackage

// File: rtl/fixed_divider_if.sv
// Request/result bundle between a client and fixed_divider.
interface fixed_divider_if #(parameter int N = 16);

    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] Result;
    logic         done;
    logic         busy;
    logic         div_zero;

    modport master (output start, A, B, input Result, done, busy, div_zero);
    modport slave  (input start, A, B, output Result, done, busy, div_zero);

endinterface

// File: rtl/fixed_div_step.sv
// One restoring division iteration on unsigned magnitudes.
module fixed_div_step #(
    parameter int N = 16
) (
    input  logic [N-1:0] rem_i,
    input  logic [N-1:0] div_i,
    input  logic         bit_i,
    output logic [N-1:0] rem_o,
    output logic         q_o
);

    logic [N:0] shifted;

    assign shifted = {rem_i, bit_i};
    assign q_o     = (shifted >= {1'b0, div_i});
    // rem_i < div_i keeps the restored remainder inside N bits, so modular subtraction is exact.
    assign rem_o   = q_o ? (shifted[N-1:0] - div_i) : shifted[N-1:0];

endmodule

// File: rtl/fixed_divider.sv
// Sequential signed QN/2 restoring divider with saturation.
// Optional build macro: FIXED_DIVIDER_ROUND_EN (round half away from zero via a guard bit).
module fixed_divider
    import fixed_divider_pkg::*;
#(
    parameter int N = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    fixed_divider_if.slave  div_if
);

    localparam int FRAC = N / 2;
`ifdef FIXED_DIVIDER_ROUND_EN
    localparam int K = N + FRAC + 1;
`else
    localparam int K = N + FRAC;
`endif
    localparam int CW = $clog2(K + 1);
    localparam logic [N-1:0] SAT_P = N'(sat_pos(N));
    localparam logic [N-1:0] SAT_N = N'(sat_neg(N));

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [K-1:0]  dq_q, dq_d;
    logic [N-1:0]  div_q, div_d;
    logic          neg_q, neg_d;
    logic          a_zero_q, a_zero_d;
    logic          b_zero_q, b_zero_d;
    logic [N-1:0]  result_q, result_d;
    logic          dz_q, dz_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic [N-1:0]  a_mag, b_mag, step_rem, final_res;
    logic [K-1:0]  mag;
    logic          step_q, ovf;

    // 0x8000 becomes the unsigned magnitude 0x8000, which still fits N bits.
    assign a_mag = div_if.A[N-1] ? (~div_if.A) + N'(1) : div_if.A;
    assign b_mag = div_if.B[N-1] ? (~div_if.B) + N'(1) : div_if.B;

    // dq_q shifts dividend bits out of the top while quotient bits enter at the bottom.
    fixed_div_step #(.N(N)) u_step (
        .rem_i (rem_q),
        .div_i (div_q),
        .bit_i (dq_q[K-1]),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

`ifdef FIXED_DIVIDER_ROUND_EN
    assign mag = {1'b0, dq_q[K-1:1]} + K'(dq_q[0]);
`else
    assign mag = dq_q;
`endif
    assign ovf = |mag[K-1:N-1];

    always_comb begin
        // With B==0 the sign of B is 0, so neg_q already carries the sign of A.
        if (a_zero_q)              final_res = '0;
        else if (b_zero_q || ovf)  final_res = neg_q ? SAT_N : SAT_P;
        else if (neg_q)            final_res = (~mag[N-1:0]) + N'(1);
        else                       final_res = mag[N-1:0];
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dq_d     = dq_q;
        div_d    = div_q;
        neg_d    = neg_q;
        a_zero_d = a_zero_q;
        b_zero_d = b_zero_q;
        result_d = result_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (div_if.start) begin
                    dq_d     = {a_mag, {(K-N){1'b0}}};
                    rem_d    = '0;
                    div_d    = b_mag;
                    neg_d    = div_if.A[N-1] ^ div_if.B[N-1];
                    a_zero_d = (div_if.A == '0);
                    b_zero_d = (div_if.B == '0);
                    cnt_d    = CW'(K);
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                rem_d = step_rem;
                dq_d  = {dq_q[K-2:0], step_q};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FINAL;
            end
            FINAL: begin
                result_d = final_res;
                dz_d     = b_zero_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dq_q     <= '0;
            div_q    <= '0;
            neg_q    <= 1'b0;
            a_zero_q <= 1'b0;
            b_zero_q <= 1'b0;
            result_q <= '0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dq_q     <= dq_d;
            div_q    <= div_d;
            neg_q    <= neg_d;
            a_zero_q <= a_zero_d;
            b_zero_q <= b_zero_d;
            result_q <= result_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign div_if.Result   = result_q;
    assign div_if.div_zero = dz_q;
    assign div_if.done     = done_q;
    assign div_if.busy     = busy_q;

endmodule

// File: tb/tb_fixed_divider.sv
// Scoreboard bench for fixed_divider at N=16 (Q8.8); honours FIXED_DIVIDER_ROUND_EN.
module tb_fixed_divider;

    localparam int N = 16;
`ifdef FIXED_DIVIDER_ROUND_EN
    localparam int K = 25;
    localparam logic [15:0] EXP_2_3 = 16'h00AB;
`else
    localparam int K = 24;
    localparam logic [15:0] EXP_2_3 = 16'h00AA;
`endif

    typedef struct {
        logic [15:0] res;
        logic        dz;
        int          acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    int   done_cnt;
    int   busy_low;
    int   last_done;
    exp_t sb[$];

    fixed_divider_if #(.N(N)) dif();

    fixed_divider #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Independent arithmetic model: integer division on magnitudes, then sign/saturation.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
        longint sa, sb_, ma, mb, q;
        logic   neg;
        logic [15:0] r;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sb_ < 0) ? -sb_ : sb_;
        neg = a[15] ^ b[15];
        if (ma == 0) r = 16'h0000;
        else if (mb == 0) r = a[15] ? 16'h8001 : 16'h7FFF;
        else begin
`ifdef FIXED_DIVIDER_ROUND_EN
            q = ((ma * 512) / mb + 1) / 2;
`else
            q = (ma * 256) / mb;
`endif
            if (q >= 32768) r = neg ? 16'h8001 : 16'h7FFF;
            else r = neg ? 16'(-q) : 16'(q);
        end
        return {(b == 16'h0000), r};
    endfunction

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && cyc >= sb[0].acc && !dif.done && !dif.busy) busy_low++;
            if (dif.done) begin
                done_cnt++;
                last_done = cyc;
                if (sb.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", dif.Result, e.res);
                    check("div_zero", dif.div_zero, e.dz);
                    check("latency", cyc - e.acc, K + 1);
                    check("busy_during_calc", busy_low, 0);
                    check("busy_at_done", dif.busy, 0);
                    busy_low = 0;
                end
            end
        end
    end

    // Call at a negedge while idle; returns at the negedge after the accepting edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] er, input logic edz);
        dif.A     = a;
        dif.B     = b;
        dif.start = 1'b1;
        sb.push_back('{er, edz, cyc + 1});
        @(negedge clk);
        dif.start = 1'b0;
        dif.A     = 16'($urandom);
        dif.B     = 16'($urandom);
    endtask

    task automatic issue_model(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] m;
        m = model(a, b);
        issue(a, b, m[15:0], m[16]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || dif.busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("timeout_idle", 1, 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d1, saved, n;
        total = 0; bad = 0; done_cnt = 0; busy_low = 0; last_done = 0;
        rst_n = 1'b0; dif.start = 1'b0; dif.A = '0; dif.B = '0;
        repeat (2) @(negedge clk);
        check("rst_result", dif.Result, 0);
        check("rst_done", dif.done, 0);
        check("rst_busy", dif.busy, 0);
        check("rst_div_zero", dif.div_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with hand-derived results.
        issue(16'h0300, 16'h0200, 16'h0180, 1'b0); check("busy_after_accept", dif.busy, 1); wait_idle();
        issue(16'hFD00, 16'h0200, 16'hFE80, 1'b0); wait_idle();
        issue(16'hFD00, 16'hFE00, 16'h0180, 1'b0); wait_idle();
        issue(16'h0200, 16'h0300, EXP_2_3,  1'b0); wait_idle();
        issue(16'h7F00, 16'h0080, 16'h7FFF, 1'b0); wait_idle();
        issue(16'h8100, 16'h0080, 16'h8001, 1'b0); wait_idle();
        issue(16'h0100, 16'h0000, 16'h7FFF, 1'b1); wait_idle();
        issue(16'hFF00, 16'h0000, 16'h8001, 1'b1); wait_idle();
        issue(16'h0000, 16'h0000, 16'h0000, 1'b1); wait_idle();
        issue(16'h8000, 16'h8000, 16'h0100, 1'b0); wait_idle();

        // Second start while busy must be ignored.
        issue(16'h0300, 16'h0200, 16'h0180, 1'b0);
        repeat (4) @(negedge clk);
        dif.A = 16'h7000; dif.B = 16'h0100; dif.start = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        wait_idle();
        saved = done_cnt;
        repeat (K + 4) @(negedge clk);
        check("ignored_start_no_done", done_cnt - saved, 0);

        // Back-to-back: start in the done cycle.
        issue(16'h0500, 16'h0200, 16'h0280, 1'b0);
        n = 0;
        while (!dif.done && n < 100) begin @(negedge clk); n++; end
        check("b2b_first_done_seen", dif.done, 1);
        d1 = cyc;
        issue_model(16'hF400, 16'h0300);
        wait_idle();
        check("b2b_spacing", last_done - d1, K + 2);

        // Reset at iteration 10 aborts without a done.
        issue(16'h0300, 16'h0200, 16'h0180, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_result", dif.Result, 0);
        check("abort_done", dif.done, 0);
        check("abort_busy", dif.busy, 0);
        check("abort_div_zero", dif.div_zero, 0);
        sb.delete();
        busy_low = 0;
        @(negedge clk);
        rst_n = 1'b1;
        saved = done_cnt;
        repeat (K + 5) @(negedge clk);
        check("abort_no_done", done_cnt - saved, 0);
        issue(16'hFD00, 16'h0200, 16'hFE80, 1'b0); wait_idle();

        // Random operands against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 6 == 0) b = 16'($urandom_range(0, 3));
            if (i % 6 == 1) b = b | 16'h4000;
            if (i % 6 == 2) a = 16'($urandom_range(0, 255));
            issue_model(a, b);
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
